// File: rtl/program_memory_loader_pkg.sv
// Shared constants for the boot-time instruction memory loader.
//   State encodings, stream header length and word assembly geometry.
package program_memory_loader_pkg;

  localparam int unsigned STATE_W        = 3;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned HEADER_BYTES   = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned COUNT_W        = HEADER_BYTES * BYTE_W;
  localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_CNT_HI = 3'd1;
  localparam logic [STATE_W-1:0] ST_CNT_LO = 3'd2;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd3;
  localparam logic [STATE_W-1:0] ST_WRITE  = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE   = 3'd5;
  localparam logic [STATE_W-1:0] ST_ERROR  = 3'd6;

  // States in which the loader consumes stream bytes.
  function automatic logic accepts_bytes(input logic [STATE_W-1:0] s);
    return (s == ST_CNT_HI) || (s == ST_CNT_LO) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/program_memory_loader_byte_word_assembler.sv
// Assembles big-endian words from accepted stream bytes.
//   clk, reset    : clock, synchronous active-low reset
//   clear         : discard any partially assembled word
//   accept        : byte_in is consumed this cycle
//   byte_in       : stream byte
//   word_c        : assembled word including the byte currently offered
//   word_valid_c  : accept of the final byte of a word
module program_memory_loader_byte_word_assembler
  import program_memory_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_c,
  output logic              word_valid_c
);

  localparam int unsigned SHIFT_W = WORD_W - BYTE_W;

  logic [SHIFT_W-1:0]    shift_q;
  logic [BYTE_CNT_W-1:0] count_q;

  // Earlier bytes sit in the upper lanes; the counter wraps after the last byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (accept) begin
      shift_q <= {shift_q[SHIFT_W-BYTE_W-1:0], byte_in};
      count_q <= BYTE_CNT_W'(count_q + BYTE_CNT_W'(1));
    end
  end

  assign word_c       = {shift_q, byte_in};
  assign word_valid_c = accept && (count_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_memory_loader.sv
// Boot-time writer for the instruction RAM: parses a word-count header, then
// writes N big-endian words to consecutive word-aligned addresses and releases
// the CPU once the whole image is in place.
//   clk, reset    : clock, synchronous active-low reset
//   Start         : request a new load (honoured in IDLE, DONE, ERROR)
//   ByteData/ByteValid/ByteReady : incoming byte stream handshake
//   WriteEnable/WriteAddress/WriteData : instruction RAM write port
//   CpuHold       : keep the processor stalled (low only in DONE)
//   LoadDone      : image fully written
//   LoadError     : header word count larger than the memory
module program_memory_loader
  import program_memory_loader_pkg::*;
#(
  parameter int unsigned MEMORY_DEPTH = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BASE_ADDRESS = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [BYTE_W-1:0]     ByteData,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  WriteEnable,
  output logic [DATA_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  CpuHold,
  output logic                  LoadDone,
  output logic                  LoadError
);

  localparam logic [COUNT_W-1:0]    DEPTH_N    = COUNT_W'(MEMORY_DEPTH);
  localparam logic [DATA_WIDTH-1:0] BASE_ADDR  = DATA_WIDTH'(BASE_ADDRESS);
  localparam logic [DATA_WIDTH-1:0] WORD_BYTES = DATA_WIDTH'(BYTES_PER_WORD);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [BYTE_W-1:0]     count_hi_q, count_hi_d;
  logic [COUNT_W-1:0]    word_count_q, word_count_d;
  logic [COUNT_W-1:0]    words_written_q, words_written_d;
  logic [DATA_WIDTH-1:0] write_address_q, write_address_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  write_enable_q, write_enable_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  load_done_q, load_done_d;
  logic                  load_error_q, load_error_d;

  logic                  transfer_c;
  logic                  asm_clear_c;
  logic                  asm_accept_c;
  logic [WORD_W-1:0]     asm_word_c;
  logic                  asm_word_valid_c;
  logic [COUNT_W-1:0]    header_n_c;
  logic [COUNT_W-1:0]    written_inc_c;

  assign transfer_c    = ByteValid && byte_ready_q;
  assign asm_accept_c  = transfer_c && (state_q == ST_DATA);
  assign header_n_c    = {count_hi_q, ByteData};
  assign written_inc_c = COUNT_W'(words_written_q + COUNT_W'(1));

  program_memory_loader_byte_word_assembler u_byte_word_assembler (
    .clk          (clk),
    .reset        (reset),
    .clear        (asm_clear_c),
    .accept       (asm_accept_c),
    .byte_in      (ByteData),
    .word_c       (asm_word_c),
    .word_valid_c (asm_word_valid_c)
  );

  // Next-state and next-output logic; outputs follow the state being entered.
  always_comb begin
    state_d         = state_q;
    count_hi_d      = count_hi_q;
    word_count_d    = word_count_q;
    words_written_d = words_written_q;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    asm_clear_c     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (Start) begin
          state_d         = ST_CNT_HI;
          write_address_d = BASE_ADDR;
          asm_clear_c     = 1'b1;
        end
      end
      ST_CNT_HI: begin
        if (transfer_c) begin
          count_hi_d = ByteData;
          state_d    = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (transfer_c) begin
          word_count_d    = header_n_c;
          words_written_d = '0;
          asm_clear_c     = 1'b1;
          if (header_n_c == '0) begin
            state_d = ST_DONE;
          end else if (header_n_c > DEPTH_N) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (asm_word_valid_c) begin
          write_data_d = DATA_WIDTH'(asm_word_c);
          state_d      = ST_WRITE;
        end
      end
      ST_WRITE: begin
        write_address_d = write_address_q + WORD_BYTES;
        words_written_d = written_inc_c;
        state_d         = (written_inc_c == word_count_q) ? ST_DONE : ST_DATA;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    byte_ready_d   = accepts_bytes(state_d);
    write_enable_d = (state_d == ST_WRITE);
    cpu_hold_d     = (state_d != ST_DONE);
    load_done_d    = (state_d == ST_DONE);
    load_error_d   = (state_d == ST_ERROR);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      count_hi_q      <= '0;
      word_count_q    <= '0;
      words_written_q <= '0;
      write_address_q <= BASE_ADDR;
      write_data_q    <= '0;
      byte_ready_q    <= 1'b0;
      write_enable_q  <= 1'b0;
      cpu_hold_q      <= 1'b1;
      load_done_q     <= 1'b0;
      load_error_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_hi_q      <= count_hi_d;
      word_count_q    <= word_count_d;
      words_written_q <= words_written_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      byte_ready_q    <= byte_ready_d;
      write_enable_q  <= write_enable_d;
      cpu_hold_q      <= cpu_hold_d;
      load_done_q     <= load_done_d;
      load_error_q    <= load_error_d;
    end
  end

  assign ByteReady    = byte_ready_q;
  assign WriteEnable  = write_enable_q;
  assign WriteAddress = write_address_q;
  assign WriteData    = write_data_q;
  assign CpuHold      = cpu_hold_q;
  assign LoadDone     = load_done_q;
  assign LoadError    = load_error_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed bench for program_memory_loader: reset, single word, full image,
// oversize header, gappy stream with ignored Start, and reset mid-load.
module tb_program_memory_loader;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [7:0]  ByteData;
  logic        ByteValid;
  logic        ByteReady;
  logic        WriteEnable;
  logic [31:0] WriteAddress;
  logic [31:0] WriteData;
  logic        CpuHold;
  logic        LoadDone;
  logic        LoadError;

  int checks;
  int failures;
  int cycle;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];

  program_memory_loader #(
    .MEMORY_DEPTH (32),
    .DATA_WIDTH   (32),
    .BASE_ADDRESS (0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Start        (Start),
    .ByteData     (ByteData),
    .ByteValid    (ByteValid),
    .ByteReady    (ByteReady),
    .WriteEnable  (WriteEnable),
    .WriteAddress (WriteAddress),
    .WriteData    (WriteData),
    .CpuHold      (CpuHold),
    .LoadDone     (LoadDone),
    .LoadError    (LoadError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (WriteEnable === 1'b1) begin
      wr_addr_q.push_back(WriteAddress);
      wr_data_q.push_back(WriteData);
      wr_cyc_q.push_back(cycle);
    end
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  // Offer one byte after an optional idle gap; returns 1 cycle after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap, input logic start_in_gap);
    bit acc;
    ByteValid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      Start = start_in_gap;
      @(posedge clk); #1;
    end
    Start     = 1'b0;
    ByteData  = b;
    ByteValid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (ByteReady === 1'b1) acc = 1'b1;
      @(posedge clk); #1;
    end
    ByteValid = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL byte_accept: byte %02h never accepted (ByteReady=%b)", b, ByteReady);
    end
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (LoadDone === 1'b1) seen = 1'b1;
    end
    @(posedge clk); #1;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_done_timeout: LoadDone=%b required 1", name, LoadDone);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; Start = 1'b0; ByteValid = 1'b0; ByteData = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (CpuHold !== 1'b1)       begin failures++; $display("FAIL reset_hold: got %b required 1", CpuHold); end
    checks++; if (WriteEnable !== 1'b0)   begin failures++; $display("FAIL reset_we: got %b required 0", WriteEnable); end
    checks++; if (WriteAddress !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h required 0", WriteAddress); end
    checks++; if (WriteData !== 32'h0)    begin failures++; $display("FAIL reset_data: got %h required 0", WriteData); end
    checks++; if (LoadDone !== 1'b0)      begin failures++; $display("FAIL reset_done: got %b required 0", LoadDone); end
    checks++; if (LoadError !== 1'b0)     begin failures++; $display("FAIL reset_err: got %b required 0", LoadError); end
    checks++; if (ByteReady !== 1'b0)     begin failures++; $display("FAIL reset_ready: got %b required 0", ByteReady); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_word();
    clear_log();
    pulse_start();
    checks++; if (ByteReady !== 1'b1) begin failures++; $display("FAIL single_ready: got %b required 1", ByteReady); end
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h20, 0, 1'b0);
    send_byte(8'h08, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h05, 0, 1'b0);
    // Write strobe is up the cycle after the last byte of the word is accepted.
    checks++; if (WriteEnable !== 1'b1)        begin failures++; $display("FAIL single_latency: WriteEnable=%b required 1", WriteEnable); end
    checks++; if (WriteData !== 32'h20080005)  begin failures++; $display("FAIL single_data: got %h required 20080005", WriteData); end
    checks++; if (WriteAddress !== 32'h0)      begin failures++; $display("FAIL single_addr: got %h required 0", WriteAddress); end
    checks++; if (ByteReady !== 1'b0)          begin failures++; $display("FAIL single_ready_write: got %b required 0", ByteReady); end
    @(posedge clk); #1;
    checks++; if (LoadDone !== 1'b1)     begin failures++; $display("FAIL single_done: got %b required 1", LoadDone); end
    checks++; if (CpuHold !== 1'b0)      begin failures++; $display("FAIL single_hold: got %b required 0", CpuHold); end
    checks++; if (WriteEnable !== 1'b0)  begin failures++; $display("FAIL single_we_off: got %b required 0", WriteEnable); end
    checks++; if (wr_addr_q.size() != 1) begin failures++; $display("FAIL single_count: got %0d strobes required 1", wr_addr_q.size()); end
  endtask

  task automatic test_full_image();
    clear_log();
    pulse_start();
    checks++; if (LoadDone !== 1'b0) begin failures++; $display("FAIL full_done_clr: got %b required 0", LoadDone); end
    checks++; if (CpuHold !== 1'b1)  begin failures++; $display("FAIL full_hold_set: got %b required 1", CpuHold); end
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h20, 0, 1'b0);
    for (int k = 0; k < 32; k++) begin
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'(k), 0, 1'b0);
    end
    wait_done("full");
    checks++;
    if (wr_addr_q.size() != 32) begin
      failures++; $display("FAIL full_count: got %0d strobes required 32", wr_addr_q.size());
    end else begin
      for (int k = 0; k < 32; k++) begin
        checks++; if (wr_addr_q[k] !== 32'(4 * k)) begin failures++; $display("FAIL full_addr[%0d]: got %h required %h", k, wr_addr_q[k], 32'(4 * k)); end
        checks++; if (wr_data_q[k] !== 32'(k))     begin failures++; $display("FAIL full_data[%0d]: got %h required %h", k, wr_data_q[k], 32'(k)); end
        if (k > 0) begin
          checks++; if (wr_cyc_q[k] - wr_cyc_q[k-1] != 5) begin failures++; $display("FAIL full_rate[%0d]: got %0d cycles required 5", k, wr_cyc_q[k] - wr_cyc_q[k-1]); end
        end
      end
    end
    checks++; if (CpuHold !== 1'b0) begin failures++; $display("FAIL full_hold: got %b required 0", CpuHold); end
  endtask

  task automatic test_oversize();
    clear_log();
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h21, 0, 1'b0);
    checks++; if (LoadError !== 1'b1) begin failures++; $display("FAIL over_err: got %b required 1", LoadError); end
    // Further bytes must be refused.
    ByteData = 8'hA5; ByteValid = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    ByteValid = 1'b0;
    checks++; if (LoadError !== 1'b1)    begin failures++; $display("FAIL over_err_hold: got %b required 1", LoadError); end
    checks++; if (ByteReady !== 1'b0)    begin failures++; $display("FAIL over_ready: got %b required 0", ByteReady); end
    checks++; if (CpuHold !== 1'b1)      begin failures++; $display("FAIL over_hold: got %b required 1", CpuHold); end
    checks++; if (LoadDone !== 1'b0)     begin failures++; $display("FAIL over_done: got %b required 0", LoadDone); end
    checks++; if (wr_addr_q.size() != 0) begin failures++; $display("FAIL over_writes: got %0d strobes required 0", wr_addr_q.size()); end
  endtask

  task automatic test_gappy_stream();
    logic [7:0] bytes [8];
    bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    clear_log();
    pulse_start();
    checks++; if (LoadError !== 1'b0) begin failures++; $display("FAIL gap_err_clr: got %b required 0", LoadError); end
    send_byte(8'h00, int'($urandom_range(0, 3)), 1'b0);
    send_byte(8'h02, int'($urandom_range(0, 3)), 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i], int'($urandom_range(1, 3)), 1'b1);
    end
    wait_done("gap");
    checks++;
    if (wr_addr_q.size() != 2) begin
      failures++; $display("FAIL gap_count: got %0d strobes required 2", wr_addr_q.size());
    end else begin
      checks++; if (wr_addr_q[0] !== 32'h0)        begin failures++; $display("FAIL gap_addr0: got %h required 0", wr_addr_q[0]); end
      checks++; if (wr_data_q[0] !== 32'h20080005) begin failures++; $display("FAIL gap_data0: got %h required 20080005", wr_data_q[0]); end
      checks++; if (wr_addr_q[1] !== 32'h4)        begin failures++; $display("FAIL gap_addr1: got %h required 4", wr_addr_q[1]); end
      checks++; if (wr_data_q[1] !== 32'hDEADBEEF) begin failures++; $display("FAIL gap_data1: got %h required deadbeef", wr_data_q[1]); end
    end
    checks++; if (CpuHold !== 1'b0) begin failures++; $display("FAIL gap_hold: got %b required 0", CpuHold); end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    send_byte(8'hCC, 0, 1'b0);
    send_byte(8'hDD, 0, 1'b0);
    send_byte(8'hEE, 0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    clear_log();
    checks++; if (CpuHold !== 1'b1)       begin failures++; $display("FAIL mid_hold: got %b required 1", CpuHold); end
    checks++; if (ByteReady !== 1'b0)     begin failures++; $display("FAIL mid_ready: got %b required 0", ByteReady); end
    checks++; if (WriteAddress !== 32'h0) begin failures++; $display("FAIL mid_addr: got %h required 0", WriteAddress); end
    // Byte offered together with Start in IDLE must not be consumed.
    Start = 1'b1; ByteData = 8'h55; ByteValid = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; ByteValid = 1'b0;
    checks++; if (ByteReady !== 1'b1) begin failures++; $display("FAIL mid_start_ready: got %b required 1", ByteReady); end
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    send_byte(8'h33, 0, 1'b0);
    send_byte(8'h44, 0, 1'b0);
    wait_done("mid");
    checks++;
    if (wr_addr_q.size() != 1) begin
      failures++; $display("FAIL mid_count: got %0d strobes required 1", wr_addr_q.size());
    end else begin
      checks++; if (wr_addr_q[0] !== 32'h0)        begin failures++; $display("FAIL mid_addr0: got %h required 0", wr_addr_q[0]); end
      checks++; if (wr_data_q[0] !== 32'h11223344) begin failures++; $display("FAIL mid_data0: got %h required 11223344", wr_data_q[0]); end
    end
  endtask

  initial begin
    checks = 0; failures = 0; cycle = 0;
    reset = 1'b0; Start = 1'b0; ByteValid = 1'b0; ByteData = 8'h00;
    #1;
    test_reset();
    test_single_word();
    test_full_image();
    test_oversize();
    test_gappy_stream();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
